// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer driving the single data-memory req/gnt/rvalid port
module lsu_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      lsu_op,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      rd,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [7:0]      mem_be,
  output logic [63:0]     mem_wdata,
  input  logic            mem_rvalid,
  input  logic [63:0]     mem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            busy,
  output logic            misalign,
  output logic [XLEN-1:0] bad_addr
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT_R = 2'd2;
  localparam logic [3:0] LSU_NONE = 4'd0, LSU_LB = 4'd1, LSU_LH = 4'd2, LSU_LW = 4'd3,
                         LSU_LD = 4'd4, LSU_LBU = 4'd5, LSU_LHU = 4'd6, LSU_LWU = 4'd7,
                         LSU_SB = 4'd8, LSU_SH = 4'd9, LSU_SW = 4'd10, LSU_SD = 4'd11;
  logic [1:0]  state;
  logic        rdy;
  logic [3:0]  op;
  logic [2:0]  off;
  logic [4:0]  rd_q;
  logic        in_valid, in_mis;
  logic [1:0]  in_sz;
  logic [7:0]  in_mask, in_be;
  logic [63:0] in_wd, sh, ld_data;
  assign busy      = state != IDLE;
  assign mem_req   = state == REQ;
  assign req_ready = rdy && state == IDLE;
  // decode incoming op: size, alignment, lane placement of store data
  always_comb begin
    in_valid = lsu_op != LSU_NONE && lsu_op <= LSU_SD;
    in_sz    = (lsu_op == LSU_LB || lsu_op == LSU_LBU || lsu_op == LSU_SB) ? 2'd0 :
               (lsu_op == LSU_LH || lsu_op == LSU_LHU || lsu_op == LSU_SH) ? 2'd1 :
               (lsu_op == LSU_LW || lsu_op == LSU_LWU || lsu_op == LSU_SW) ? 2'd2 : 2'd3;
    in_mis   = (in_sz == 2'd1 && addr[0]) || (in_sz == 2'd2 && |addr[1:0]) ||
               (in_sz == 2'd3 && |addr[2:0]);
    in_mask  = in_sz == 2'd0 ? 8'h01 : in_sz == 2'd1 ? 8'h03 : in_sz == 2'd2 ? 8'h0F : 8'hFF;
    in_be    = in_mask << addr[2:0];
    in_wd    = 64'(wdata) << {addr[2:0], 3'b000};
  end
  // pick the addressed lane out of the read doubleword and extend it
  always_comb begin
    sh      = mem_rdata >> {off, 3'b000};
    ld_data = op == LSU_LB  ? {{56{sh[7]}}, sh[7:0]} :
              op == LSU_LH  ? {{48{sh[15]}}, sh[15:0]} :
              op == LSU_LW  ? {{32{sh[31]}}, sh[31:0]} :
              op == LSU_LBU ? {56'b0, sh[7:0]} :
              op == LSU_LHU ? {48'b0, sh[15:0]} :
              op == LSU_LWU ? {32'b0, sh[31:0]} : sh;
  end
  // ready flag keeps req_ready low until the first edge after reset release
  always_ff @(posedge clk or posedge rst)
    if (rst) rdy <= 1'b0;
    else     rdy <= 1'b1;
  // sequencing FSM with latched request and registered result pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op        <= LSU_NONE;
      off       <= '0;
      rd_q      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      misalign  <= 1'b0;
      bad_addr  <= '0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE:
          if (rdy && req_valid && in_valid) begin
            if (in_mis) begin
              misalign <= 1'b1;
              bad_addr <= addr;
            end else begin
              op        <= lsu_op;
              off       <= addr[2:0];
              rd_q      <= rd;
              mem_we    <= lsu_op >= LSU_SB;
              mem_addr  <= {addr[XLEN-1:3], 3'b000};
              mem_be    <= in_be;
              mem_wdata <= in_wd;
              state     <= REQ;
            end
          end
        REQ:
          if (mem_gnt) state <= mem_we ? IDLE : WAIT_R;
        WAIT_R:
          if (mem_rvalid) begin
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= XLEN'(ld_data);
            state    <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl
module tb_lsu_ctrl;
  logic        clk = 0, rst = 1;
  logic        req_valid = 0, req_ready;
  logic [3:0]  lsu_op = 0;
  logic [63:0] addr = 0, wdata = 0;
  logic [4:0]  rd = 0;
  logic        mem_req, mem_gnt = 0, mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;
  logic        mem_rvalid = 0;
  logic [63:0] mem_rdata = 0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        busy, misalign;
  logic [63:0] bad_addr;
  int n_chk = 0, n_fail = 0;

  lsu_ctrl #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .lsu_op(lsu_op),
    .addr(addr), .wdata(wdata), .rd(rd), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .busy(busy), .misalign(misalign), .bad_addr(bad_addr)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [3:0] o, input logic [63:0] a, input logic [63:0] d, input logic [4:0] r);
    req_valid = 1; lsu_op = o; addr = a; wdata = d; rd = r;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", req_ready); end
    n_chk++; if ({mem_req, mem_we, mem_be, busy, wb_valid, misalign} !== 13'b0) begin n_fail++; $display("FAIL rst_ctl: got %b want 0", {mem_req, mem_we, mem_be, busy, wb_valid, misalign}); end
    n_chk++; if ({mem_addr, mem_wdata, wb_data, bad_addr, wb_rd} !== 261'b0) begin n_fail++; $display("FAIL rst_data: nonzero data output"); end
    rst = 0;
    @(negedge clk);
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_store_sd;
    issue(4'd11, 64'h1000, 64'h1122334455667788, 5'd0);
    @(negedge clk);
    req_valid = 0; mem_gnt = 1;
    n_chk++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL sd_req_we: got %b%b want 11", mem_req, mem_we); end
    n_chk++; if (mem_addr !== 64'h1000) begin n_fail++; $display("FAIL sd_addr: got %h want 1000", mem_addr); end
    n_chk++; if (mem_be !== 8'hFF) begin n_fail++; $display("FAIL sd_be: got %h want ff", mem_be); end
    n_chk++; if (mem_wdata !== 64'h1122334455667788) begin n_fail++; $display("FAIL sd_wdata: got %h want 1122334455667788", mem_wdata); end
    n_chk++; if (busy !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL sd_busy: got busy=%b ready=%b want 1/0", busy, req_ready); end
    @(negedge clk);
    mem_gnt = 0;
    n_chk++; if (busy !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL sd_done: got busy=%b req=%b ready=%b want 0/0/1", busy, mem_req, req_ready); end
    n_chk++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL sd_no_wb: got %b want 0", wb_valid); end
  endtask

  task automatic test_store_sb;
    issue(4'd8, 64'h1003, 64'h00000000000000AB, 5'd0);
    @(negedge clk);
    req_valid = 0; mem_gnt = 1;
    n_chk++; if (mem_be !== 8'h08) begin n_fail++; $display("FAIL sb_be: got %h want 08", mem_be); end
    n_chk++; if (mem_wdata !== 64'h00000000AB000000) begin n_fail++; $display("FAIL sb_wdata: got %h want 00000000ab000000", mem_wdata); end
    n_chk++; if (mem_addr !== 64'h1000) begin n_fail++; $display("FAIL sb_addr: got %h want 1000", mem_addr); end
    @(negedge clk);
    mem_gnt = 0;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sb_done: got %b want 0", busy); end
  endtask

  task automatic test_load(input logic [3:0] o, input logic [63:0] exp);
    issue(o, 64'h2005, 64'h0, 5'd7);
    @(negedge clk);
    req_valid = 0; mem_gnt = 1;
    n_chk++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== 8'h20 || mem_addr !== 64'h2000) begin n_fail++; $display("FAIL ld_req: got req=%b we=%b be=%h addr=%h want 1/0/20/2000", mem_req, mem_we, mem_be, mem_addr); end
    @(negedge clk);
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'h0000800000000000;
    n_chk++; if (mem_req !== 1'b0 || busy !== 1'b1 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL ld_wait: got req=%b busy=%b wb=%b want 0/1/0", mem_req, busy, wb_valid); end
    @(negedge clk);
    mem_rvalid = 0;
    n_chk++; if (wb_valid !== 1'b1 || wb_rd !== 5'd7) begin n_fail++; $display("FAIL ld_wb: got valid=%b rd=%0d want 1/7", wb_valid, wb_rd); end
    n_chk++; if (wb_data !== exp) begin n_fail++; $display("FAIL ld_data op%0d: got %h want %h", o, wb_data, exp); end
    n_chk++; if (req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL ld_ready: got ready=%b busy=%b want 1/0", req_ready, busy); end
    @(negedge clk);
    n_chk++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL ld_pulse: got %b want 0", wb_valid); end
  endtask

  task automatic test_misalign;
    issue(4'd3, 64'h2006, 64'h0, 5'd4);
    @(negedge clk);
    req_valid = 0;
    n_chk++; if (misalign !== 1'b1 || bad_addr !== 64'h2006) begin n_fail++; $display("FAIL mis_flag: got %b addr=%h want 1/2006", misalign, bad_addr); end
    n_chk++; if (mem_req !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL mis_bus: got req=%b busy=%b ready=%b want 0/0/1", mem_req, busy, req_ready); end
    @(negedge clk);
    n_chk++; if (misalign !== 1'b0 || bad_addr !== 64'h2006 || mem_req !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: got %b addr=%h req=%b want 0/2006/0", misalign, bad_addr, mem_req); end
    issue(4'd2, 64'h2001, 64'h0, 5'd4);
    @(negedge clk);
    req_valid = 0;
    n_chk++; if (misalign !== 1'b1 || bad_addr !== 64'h2001) begin n_fail++; $display("FAIL mis_lh: got %b addr=%h want 1/2001", misalign, bad_addr); end
    issue(4'd4, 64'h2004, 64'h0, 5'd4);
    @(negedge clk);
    req_valid = 0;
    n_chk++; if (misalign !== 1'b1 || bad_addr !== 64'h2004 || busy !== 1'b0) begin n_fail++; $display("FAIL mis_ld: got %b addr=%h busy=%b want 1/2004/0", misalign, bad_addr, busy); end
    @(negedge clk);
  endtask

  task automatic test_discard;
    issue(4'd0, 64'h3000, 64'h0, 5'd1);
    @(negedge clk);
    lsu_op = 4'd13;
    n_chk++; if (busy !== 1'b0 || mem_req !== 1'b0 || misalign !== 1'b0) begin n_fail++; $display("FAIL none_op: got busy=%b req=%b mis=%b want 0", busy, mem_req, misalign); end
    @(negedge clk);
    req_valid = 0;
    n_chk++; if (busy !== 1'b0 || mem_req !== 1'b0 || misalign !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL op13: got busy=%b req=%b mis=%b ready=%b want 0/0/0/1", busy, mem_req, misalign, req_ready); end
  endtask

  task automatic test_ld_stall;
    int wb_cnt = 0;
    int bad = 0;
    issue(4'd4, 64'h3008, 64'h0, 5'd3);
    @(negedge clk);
    req_valid = 0; mem_rvalid = 1; mem_rdata = 64'hDEADDEADDEADDEAD;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_gnt = 1;
      if (i == 1) mem_rvalid = 0;
      n_chk++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 64'h3008 || mem_be !== 8'hFF || req_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; bad++; $display("FAIL stall_req%0d: got req=%b we=%b addr=%h be=%h ready=%b busy=%b", i, mem_req, mem_we, mem_addr, mem_be, req_ready, busy); end
      if (wb_valid) wb_cnt++;
      @(negedge clk);
    end
    mem_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin mem_rvalid = 1; mem_rdata = 64'h0123456789ABCDEF; end
      n_chk++; if (mem_req !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin n_fail++; bad++; $display("FAIL stall_wait%0d: got req=%b busy=%b ready=%b want 0/1/0", i, mem_req, busy, req_ready); end
      if (wb_valid) wb_cnt++;
      @(negedge clk);
    end
    mem_rvalid = 0;
    n_chk++; if (wb_data !== 64'h0123456789ABCDEF || wb_rd !== 5'd3) begin n_fail++; $display("FAIL stall_data: got %h rd=%0d want 0123456789abcdef/3", wb_data, wb_rd); end
    for (int i = 0; i < 4; i++) begin
      if (wb_valid) wb_cnt++;
      @(negedge clk);
    end
    n_chk++; if (wb_cnt != 1) begin n_fail++; $display("FAIL stall_wb_count: got %0d want 1", wb_cnt); end
  endtask

  task automatic test_back_to_back;
    issue(4'd7, 64'h2004, 64'h0, 5'd0);
    @(negedge clk);
    req_valid = 0; mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'h8765432100000000;
    @(negedge clk);
    mem_rvalid = 0;
    n_chk++; if (wb_valid !== 1'b1 || wb_rd !== 5'd0 || wb_data !== 64'h0000000087654321) begin n_fail++; $display("FAIL b2b_lwu: got v=%b rd=%0d data=%h want 1/0/0000000087654321", wb_valid, wb_rd, wb_data); end
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", req_ready); end
    issue(4'd9, 64'h1006, 64'h000000000000BEEF, 5'd0);
    @(negedge clk);
    req_valid = 0; mem_gnt = 1;
    n_chk++; if (mem_req !== 1'b1 || mem_be !== 8'hC0 || mem_wdata !== 64'hBEEF000000000000 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_sh: got req=%b be=%h wdata=%h wb=%b want 1/c0/beef000000000000/0", mem_req, mem_be, mem_wdata, wb_valid); end
    @(negedge clk);
    mem_gnt = 0;
  endtask

  task automatic test_reset_mid;
    issue(4'd3, 64'h4000, 64'h0, 5'd9);
    @(negedge clk);
    req_valid = 0; mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_in_wait: got %b want 1", busy); end
    rst = 1;
    #1;
    n_chk++; if ({mem_req, mem_we, mem_be, busy, wb_valid, misalign, req_ready} !== 14'b0) begin n_fail++; $display("FAIL mid_rst_ctl: got %b want 0", {mem_req, mem_we, mem_be, busy, wb_valid, misalign, req_ready}); end
    n_chk++; if ({mem_addr, mem_wdata, wb_data, bad_addr} !== 256'b0) begin n_fail++; $display("FAIL mid_rst_data: nonzero data output"); end
    @(negedge clk);
    rst = 0; mem_rvalid = 1; mem_rdata = 64'hFFFFFFFFFFFFFFFF;
    @(negedge clk);
    mem_rvalid = 0;
    n_chk++; if (wb_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_after: got wb=%b busy=%b ready=%b want 0/0/1", wb_valid, busy, req_ready); end
    @(negedge clk);
    n_chk++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after2: got %b want 0", wb_valid); end
  endtask

  initial begin
    test_reset;
    test_store_sd;
    test_store_sb;
    test_load(4'd1, 64'hFFFFFFFFFFFFFF80);
    test_load(4'd5, 64'h0000000000000080);
    test_misalign;
    test_discard;
    test_ld_stall;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
